// File: rtl/mips_pkg.sv
// mips_pkg: shared EX-stage constants (funct codes, alu_op encoding, multiplier states, EX/MEM entry layout)
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_RTYPE = 2'b10, ALU_ORI = 2'b11} alu_op_t;
  typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_t;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_MFHI = 6'h10, F_MFLO = 6'h12,
                         F_MULT = 6'h18, F_MULTU = 6'h19, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                         F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                         F_SLT = 6'h2A, F_SLTU = 6'h2B;
  typedef struct packed {
    logic valid, reg_write, mem_to_reg, mem_read, mem_write, branch_taken;
    logic [DATA_W-1:0] branch_target, alu_result, store_data;
    logic [REG_W-1:0] dest;
  } exmem_t;
endpackage

// File: rtl/mips_ex_if.sv
// mips_ex_if: ID/EX input bundle and EX/MEM output bundle with valid/ready on each side; master = upstream/downstream peers, slave = EX stage
interface mips_ex_if;
  import mips_pkg::*;
  logic idex_valid, idex_ready;
  logic idex_reg_write, idex_mem_to_reg, idex_mem_read, idex_mem_write, idex_branch, idex_alu_src, idex_reg_dst;
  logic [1:0] idex_alu_op;
  logic [DATA_W-1:0] idex_pc4, idex_rs_data, idex_rt_data, idex_imm;
  logic [REG_W-1:0] idex_rt, idex_rd, idex_shamt;
  logic [5:0] idex_funct;
  logic exmem_ready, exmem_valid;
  logic exmem_reg_write, exmem_mem_to_reg, exmem_mem_read, exmem_mem_write, exmem_branch_taken;
  logic [DATA_W-1:0] exmem_branch_target, exmem_alu_result, exmem_store_data;
  logic [REG_W-1:0] exmem_dest;
  modport master(
    output idex_valid, idex_reg_write, idex_mem_to_reg, idex_mem_read, idex_mem_write, idex_branch,
           idex_alu_src, idex_reg_dst, idex_alu_op, idex_pc4, idex_rs_data, idex_rt_data, idex_imm,
           idex_rt, idex_rd, idex_shamt, idex_funct, exmem_ready,
    input  idex_ready, exmem_valid, exmem_reg_write, exmem_mem_to_reg, exmem_mem_read, exmem_mem_write,
           exmem_branch_taken, exmem_branch_target, exmem_alu_result, exmem_store_data, exmem_dest
  );
  modport slave(
    input  idex_valid, idex_reg_write, idex_mem_to_reg, idex_mem_read, idex_mem_write, idex_branch,
           idex_alu_src, idex_reg_dst, idex_alu_op, idex_pc4, idex_rs_data, idex_rt_data, idex_imm,
           idex_rt, idex_rd, idex_shamt, idex_funct, exmem_ready,
    output idex_ready, exmem_valid, exmem_reg_write, exmem_mem_to_reg, exmem_mem_read, exmem_mem_write,
           exmem_branch_taken, exmem_branch_target, exmem_alu_result, exmem_store_data, exmem_dest
  );
endinterface

// File: rtl/mips_mul_seq.sv
// mips_mul_seq: sequential shift-add multiplier (start/is_signed/a/b/abort in; done pulses on the cycle of the last step, product valid afterwards)
module mips_mul_seq #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] product
);
  localparam int CW = $clog2(MUL_CYCLES);
  logic busy, neg;
  logic [CW-1:0] cnt;
  logic [31:0] mplier;
  logic [63:0] mcand, acc;
  assign done = busy && cnt == CW'(MUL_CYCLES - 1);
  assign product = neg ? -acc : acc;
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy <= 1'b0;
      neg <= 1'b0;
      cnt <= '0;
      mplier <= '0;
      mcand <= '0;
      acc <= '0;
    end else if (start) begin
      busy <= 1'b1;
      neg <= is_signed && (a[31] ^ b[31]);
      cnt <= '0;
      mplier <= (is_signed && a[31]) ? -a : a;
      mcand <= {32'b0, (is_signed && b[31]) ? -b : b};
      acc <= '0;
    end else if (busy) begin
      acc <= acc + (mplier[0] ? mcand : 64'b0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/mips_ex_stage.sv
// mips_ex_stage: MIPS execute stage (clk, rst, flush; ex = ID/EX in + EX/MEM out via mips_ex_if; mul_busy = multiplier not idle)
module mips_ex_stage
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  mips_ex_if.slave ex,
  output logic mul_busy
);
  mul_state_t state_q, state_n;
  exmem_t em, alu_e;
  logic slot_free, accept, is_mul, mul_done, hilo_we, valid_funct;
  logic [DATA_W-1:0] b, hi, lo, result;
  logic [63:0] product;
  assign slot_free = !em.valid || ex.exmem_ready;
  assign ex.idex_ready = state_q == IDLE && slot_free && !rst;
  assign accept = ex.idex_valid && ex.idex_ready && !flush;
  assign is_mul = ex.idex_alu_op == ALU_RTYPE && (ex.idex_funct == F_MULT || ex.idex_funct == F_MULTU);
  assign b = ex.idex_alu_src ? ex.idex_imm : ex.idex_rt_data;
  assign hilo_we = state_q == DONE && slot_free && !flush;
  assign mul_busy = state_q != IDLE;
  always_comb begin
    valid_funct = 1'b1;
    result = '0;
    case (ex.idex_alu_op)
      ALU_ADD: result = ex.idex_rs_data + b;
      ALU_SUB: result = ex.idex_rs_data - b;
      ALU_ORI: result = ex.idex_rs_data | b;
      default:
        case (ex.idex_funct)
          F_ADD, F_ADDU: result = ex.idex_rs_data + b;
          F_SUB, F_SUBU: result = ex.idex_rs_data - b;
          F_AND: result = ex.idex_rs_data & b;
          F_OR: result = ex.idex_rs_data | b;
          F_XOR: result = ex.idex_rs_data ^ b;
          F_NOR: result = ~(ex.idex_rs_data | b);
          F_SLT: result = {31'b0, $signed(ex.idex_rs_data) < $signed(b)};
          F_SLTU: result = {31'b0, ex.idex_rs_data < b};
          F_SLL: result = ex.idex_rt_data << ex.idex_shamt;
          F_SRL: result = ex.idex_rt_data >> ex.idex_shamt;
          F_SRA: result = $signed(ex.idex_rt_data) >>> ex.idex_shamt;
          F_MFHI: result = hi;
          F_MFLO: result = lo;
          default: valid_funct = 1'b0;
        endcase
    endcase
  end
  assign alu_e = '{valid: 1'b1, reg_write: ex.idex_reg_write && valid_funct, mem_to_reg: ex.idex_mem_to_reg,
                   mem_read: ex.idex_mem_read, mem_write: ex.idex_mem_write,
                   branch_taken: ex.idex_branch && ex.idex_rs_data == b,
                   branch_target: ex.idex_pc4 + {ex.idex_imm[DATA_W-3:0], 2'b00}, alu_result: result,
                   store_data: ex.idex_rt_data, dest: ex.idex_reg_dst ? ex.idex_rd : ex.idex_rt};
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: state_n = (accept && is_mul) ? MUL : IDLE;
      MUL: state_n = flush ? IDLE : mul_done ? DONE : MUL;
      DONE: state_n = (flush || slot_free) ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi <= '0;
      lo <= '0;
      em <= '0;
    end else begin
      state_q <= state_n;
      if (hilo_we) begin
        hi <= product[63:32];
        lo <= product[31:0];
        em <= '{valid: 1'b1, alu_result: product[31:0], default: '0};
      end else if (accept && !is_mul) em <= alu_e;
      else if (slot_free) em.valid <= 1'b0;
    end
  end
  mips_mul_seq #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(accept && is_mul),
    .is_signed(ex.idex_funct == F_MULT),
    .abort(flush),
    .a(ex.idex_rs_data),
    .b(ex.idex_rt_data),
    .done(mul_done),
    .product(product)
  );
  assign ex.exmem_valid = em.valid;
  assign ex.exmem_reg_write = em.reg_write;
  assign ex.exmem_mem_to_reg = em.mem_to_reg;
  assign ex.exmem_mem_read = em.mem_read;
  assign ex.exmem_mem_write = em.mem_write;
  assign ex.exmem_branch_taken = em.branch_taken;
  assign ex.exmem_branch_target = em.branch_target;
  assign ex.exmem_alu_result = em.alu_result;
  assign ex.exmem_store_data = em.store_data;
  assign ex.exmem_dest = em.dest;
endmodule
